// File: rtl/multi_pulse_generator.sv
// NUM_CH independent programmable pulse trains (continuous / one-shot / burst)
// sharing a single configuration write port with shadowed, period-aligned updates.
module multi_pulse_generator #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int DEF_PERIOD   = 3,
  parameter int DEF_DURATION = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duration,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_burst,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic              cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] MODE_CONT    = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_BURST   = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  localparam logic [CH_W:0] NUM_CH_W = (CH_W + 1)'(NUM_CH);

  logic cfgValid;
  logic cfgErr_q;
  logic cfgErr_d;

  // A rejected write must leave every channel untouched, so validity gates all writes.
  always_comb begin
    cfgValid = 1'b1;
    if (cfg_period < CNT_W'(2)) begin
      cfgValid = 1'b0;
    end
    if ((cfg_duration == '0) || (cfg_duration >= cfg_period)) begin
      cfgValid = 1'b0;
    end
    if (cfg_mode == MODE_RSVD) begin
      cfgValid = 1'b0;
    end
    if ((cfg_mode == MODE_BURST) && (cfg_burst == '0)) begin
      cfgValid = 1'b0;
    end
    if ({1'b0, cfg_ch} >= NUM_CH_W) begin
      cfgValid = 1'b0;
    end
  end

  assign cfgErr_d = cfg_we & ~cfgValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfgErr_q <= 1'b0;
    end else begin
      cfgErr_q <= cfgErr_d;
    end
  end

  assign cfg_err = cfgErr_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] burstCnt_q, burstCnt_d;
    logic [CNT_W-1:0] actPeriod_q, actPeriod_d;
    logic [CNT_W-1:0] actDuration_q, actDuration_d;
    logic [1:0]       actMode_q, actMode_d;
    logic [CNT_W-1:0] actBurst_q, actBurst_d;
    logic [CNT_W-1:0] shPeriod_q, shPeriod_d;
    logic [CNT_W-1:0] shDuration_q, shDuration_d;
    logic [1:0]       shMode_q, shMode_d;
    logic [CNT_W-1:0] shBurst_q, shBurst_d;
    logic             pending_q, pending_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;
    logic             wrHit;
    logic             wrap;
    logic             finish;

    assign wrHit  = cfg_we && cfgValid && (cfg_ch == CH_W'(i));
    assign wrap   = (cnt_q == (actPeriod_q - CNT_W'(1)));
    assign finish = wrap && ((actMode_q == MODE_ONESHOT) ||
                             ((actMode_q == MODE_BURST) && (burstCnt_q >= actBurst_q)));

    // Shadow updates only reach the active set at a period boundary (or while idle),
    // so a running channel never sees a period with mixed settings.
    always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      burstCnt_d    = burstCnt_q;
      actPeriod_d   = actPeriod_q;
      actDuration_d = actDuration_q;
      actMode_d     = actMode_q;
      actBurst_d    = actBurst_q;
      shPeriod_d    = shPeriod_q;
      shDuration_d  = shDuration_q;
      shMode_d      = shMode_q;
      shBurst_d     = shBurst_q;
      pending_d     = pending_q;
      pulse_d       = 1'b0;
      done_d        = 1'b0;

      if (wrHit) begin
        shPeriod_d   = cfg_period;
        shDuration_d = cfg_duration;
        shMode_d     = cfg_mode;
        shBurst_d    = cfg_burst;
        pending_d    = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (wrHit) begin
            actPeriod_d   = cfg_period;
            actDuration_d = cfg_duration;
            actMode_d     = cfg_mode;
            actBurst_d    = cfg_burst;
            pending_d     = 1'b0;
          end
          if (start[i] && !stop[i]) begin
            state_d    = RUN;
            cnt_d      = '0;
            burstCnt_d = CNT_W'(1);
            pulse_d    = 1'b1;
          end
        end

        RUN: begin
          if (stop[i] || finish) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = !stop[i];
            if (wrHit) begin
              actPeriod_d   = cfg_period;
              actDuration_d = cfg_duration;
              actMode_d     = cfg_mode;
              actBurst_d    = cfg_burst;
            end else if (pending_q) begin
              actPeriod_d   = shPeriod_q;
              actDuration_d = shDuration_q;
              actMode_d     = shMode_q;
              actBurst_d    = shBurst_q;
            end
            pending_d = 1'b0;
          end else if (wrap) begin
            cnt_d = '0;
            if (actMode_q == MODE_BURST) begin
              burstCnt_d = burstCnt_q + CNT_W'(1);
            end
            // A write landing on this very edge stays pending for the next wrap.
            if (pending_q) begin
              actPeriod_d   = shPeriod_q;
              actDuration_d = shDuration_q;
              actMode_d     = shMode_q;
              actBurst_d    = shBurst_q;
              pending_d     = wrHit;
            end
            pulse_d = (CNT_W'(0) < actDuration_d);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            pulse_d = (cnt_d < actDuration_q);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q       <= IDLE;
        cnt_q         <= '0;
        burstCnt_q    <= '0;
        actPeriod_q   <= CNT_W'(DEF_PERIOD);
        actDuration_q <= CNT_W'(DEF_DURATION);
        actMode_q     <= MODE_CONT;
        actBurst_q    <= CNT_W'(1);
        shPeriod_q    <= CNT_W'(DEF_PERIOD);
        shDuration_q  <= CNT_W'(DEF_DURATION);
        shMode_q      <= MODE_CONT;
        shBurst_q     <= CNT_W'(1);
        pending_q     <= 1'b0;
        pulse_q       <= 1'b0;
        done_q        <= 1'b0;
      end else begin
        state_q       <= state_d;
        cnt_q         <= cnt_d;
        burstCnt_q    <= burstCnt_d;
        actPeriod_q   <= actPeriod_d;
        actDuration_q <= actDuration_d;
        actMode_q     <= actMode_d;
        actBurst_q    <= actBurst_d;
        shPeriod_q    <= shPeriod_d;
        shDuration_q  <= shDuration_d;
        shMode_q      <= shMode_d;
        shBurst_q     <= shBurst_d;
        pending_q     <= pending_d;
        pulse_q       <= pulse_d;
        done_q        <= done_d;
      end
    end

    assign pulse[i] = pulse_q;
    assign busy[i]  = (state_q == RUN);
    assign done[i]  = done_q;
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed scoreboard bench for multi_pulse_generator: expected per-cycle channel
// outputs are queued when stimulus is driven and checked as each edge completes.
module tb_multi_pulse_generator;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_duration;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_burst;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic              cfg_err;

  logic [2:0] start3;
  logic [2:0] stop3;
  logic [2:0] pulse3;
  logic [2:0] busy3;
  logic [2:0] done3;
  logic       cfg_err3;

  multi_pulse_generator #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_PERIOD(3), .DEF_DURATION(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_duration(cfg_duration), .cfg_mode(cfg_mode),
    .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .pulse(pulse), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // Three-channel instance so that cfg_ch == NUM_CH is representable on the port.
  multi_pulse_generator #(
    .NUM_CH(3), .CNT_W(CNT_W), .DEF_PERIOD(3), .DEF_DURATION(2)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_duration(cfg_duration), .cfg_mode(cfg_mode),
    .cfg_burst(cfg_burst), .start(start3), .stop(stop3),
    .pulse(pulse3), .busy(busy3), .done(done3), .cfg_err(cfg_err3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string tag;
    int    ch;
    logic  p;
    logic  b;
    logic  d;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkVec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cyc) begin
        checkBit($sformatf("%s_c%0d_pulse%0d", sb[k].tag, cyc, sb[k].ch), pulse[sb[k].ch], sb[k].p);
        checkBit($sformatf("%s_c%0d_busy%0d", sb[k].tag, cyc, sb[k].ch), busy[sb[k].ch], sb[k].b);
        checkBit($sformatf("%s_c%0d_done%0d", sb[k].tag, cyc, sb[k].ch), done[sb[k].ch], sb[k].d);
        sb.delete(k);
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] ch,
                               input logic [CNT_W-1:0] per, input logic [CNT_W-1:0] dur,
                               input logic [1:0] mode, input logic [CNT_W-1:0] bst,
                               input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp);
    cfg_we       = we;
    cfg_ch       = ch;
    cfg_period   = per;
    cfg_duration = dur;
    cfg_mode     = mode;
    cfg_burst    = bst;
    start        = st;
    stop         = sp;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 2'd0, '0, '0, 2'd0, '0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  // Running channel started at cycle s: high while (c - s) mod P < D.
  task automatic expectRun(input string tag, input int ch, input int per, input int dur,
                           input int s, input int first, input int last);
    exp_t e;
    for (int c = first; c <= last; c++) begin
      e.cyc = c; e.tag = tag; e.ch = ch;
      e.p = (((c - s) % per) < dur);
      e.b = 1'b1; e.d = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic expectIdle(input string tag, input int ch, input int c, input logic dn);
    exp_t e;
    e.cyc = c; e.tag = tag; e.ch = ch;
    e.p = 1'b0; e.b = 1'b0; e.d = dn;
    sb.push_back(e);
  endtask

  int s0, s1, s2, s3, s4, s5;
  int highs;
  logic [CNT_W-1:0] badPer [5]  = '{8'd3, 8'd1, 8'd4, 8'd4, 8'd4};
  logic [CNT_W-1:0] badDur [5]  = '{8'd3, 8'd1, 8'd2, 8'd2, 8'd0};
  logic [1:0]       badMode[5]  = '{2'd0, 2'd0, 2'd3, 2'd2, 2'd0};
  logic [CNT_W-1:0] badBst [5]  = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd1};

  initial begin
    start3 = '0;
    stop3  = '0;
    rst_n  = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    checkVec("rst_pulse", 16'(pulse), 16'h0);
    checkVec("rst_busy", 16'(busy), 16'h0);
    checkVec("rst_done", 16'(done), 16'h0);
    checkBit("rst_cfg_err", cfg_err, 1'b0);
    checkVec("rst_aux", {7'd0, pulse3, busy3, done3}, 16'h0);
    rst_n = 1'b1;

    // Defaults on ch0: P=3, D=2 -> 20 highs in 30 cycles.
    s0 = cyc + 1;
    expectRun("dflt", 0, 3, 2, s0, s0, s0 + 29);
    applyStimulus(1'b0, 2'd0, '0, '0, 2'd0, '0, 4'b0001, '0);
    highs = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 0) idleInputs();
      highs += int'(pulse[0]);
    end
    checkInt("dflt_highs", highs, 20);

    // ch1: write P=5/D=2 with start, reprogram to P=4/D=3 mid-period, start while running.
    s1 = cyc + 1;
    expectRun("ch1_p5d2", 1, 5, 2, s1, s1, s1 + 9);
    expectRun("ch1_p4d3", 1, 4, 3, s1 + 10, s1 + 10, s1 + 21);
    applyStimulus(1'b1, 2'd1, 8'd5, 8'd2, 2'd0, 8'd1, 4'b0010, '0);
    for (int k = 0; k < 22; k++) begin
      tick();
      if (k == 0) begin
        checkBit("ch1_wr0_err", cfg_err, 1'b0);
        idleInputs();
      end
      if (k == 6) applyStimulus(1'b1, 2'd1, 8'd4, 8'd3, 2'd0, 8'd1, '0, '0);
      if (k == 7) begin
        checkBit("ch1_wr1_err", cfg_err, 1'b0);
        idleInputs();
      end
      if (k == 12) applyStimulus(1'b0, 2'd0, '0, '0, 2'd0, '0, 4'b0010, '0);
      if (k == 13) idleInputs();
    end
    expectIdle("ch1_stop", 1, cyc + 1, 1'b0);
    expectIdle("ch1_stopped", 1, cyc + 2, 1'b0);
    applyStimulus(1'b0, 2'd0, '0, '0, 2'd0, '0, '0, 4'b0010);
    tick();
    idleInputs();
    tick();

    // ch2 one-shot P=4/D=1.
    s2 = cyc + 1;
    expectRun("ch2_os", 2, 4, 1, s2, s2, s2 + 3);
    expectIdle("ch2_os_done", 2, s2 + 4, 1'b1);
    expectIdle("ch2_os_after", 2, s2 + 5, 1'b0);
    applyStimulus(1'b1, 2'd2, 8'd4, 8'd1, 2'd1, 8'd1, 4'b0100, '0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) idleInputs();
    end

    // ch3 burst of 3, P=4/D=2 -> 6 high cycles then done.
    s3 = cyc + 1;
    expectRun("ch3_burst", 3, 4, 2, s3, s3, s3 + 11);
    expectIdle("ch3_burst_done", 3, s3 + 12, 1'b1);
    expectIdle("ch3_burst_after", 3, s3 + 13, 1'b0);
    applyStimulus(1'b1, 2'd3, 8'd4, 8'd2, 2'd2, 8'd3, 4'b1000, '0);
    highs = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 0) idleInputs();
      highs += int'(pulse[3]);
    end
    checkInt("ch3_burst_highs", highs, 6);

    // Invalid writes to running ch0: one-cycle cfg_err, pattern undisturbed.
    expectRun("ch0_inv", 0, 3, 2, s0, cyc + 1, cyc + 10);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd0, badPer[i], badDur[i], badMode[i], badBst[i], '0, '0);
      tick();
      checkBit($sformatf("inv%0d_err", i), cfg_err, 1'b1);
      idleInputs();
      tick();
      checkBit($sformatf("inv%0d_clr", i), cfg_err, 1'b0);
    end
    applyStimulus(1'b1, 2'd3, 8'd6, 8'd2, 2'd0, 8'd1, '0, '0);
    tick();
    checkBit("oob_ch_err", cfg_err3, 1'b1);
    checkBit("inrange_ch_err", cfg_err, 1'b0);
    idleInputs();
    tick();
    checkBit("oob_ch_clr", cfg_err3, 1'b0);

    // start+stop on idle ch2 (with boundary-valid P=2/D=1 write): stays idle.
    expectIdle("ch2_ss", 2, cyc + 1, 1'b0);
    expectIdle("ch2_ss2", 2, cyc + 2, 1'b0);
    applyStimulus(1'b1, 2'd2, 8'd2, 8'd1, 2'd0, 8'd1, 4'b0100, 4'b0100);
    tick();
    checkBit("p2d1_err", cfg_err, 1'b0);
    idleInputs();
    tick();

    // Stop mid-burst on ch3: drop on the stop edge, no done afterwards.
    s3 = cyc + 1;
    expectRun("ch3_b2", 3, 4, 2, s3, s3, s3 + 5);
    for (int c = s3 + 6; c <= s3 + 9; c++) expectIdle("ch3_stopped", 3, c, 1'b0);
    applyStimulus(1'b1, 2'd3, 8'd4, 8'd2, 2'd2, 8'd3, 4'b1000, '0);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) idleInputs();
      if (k == 5) applyStimulus(1'b0, 2'd0, '0, '0, 2'd0, '0, '0, 4'b1000);
      if (k == 6) idleInputs();
    end

    // All channels running, then asynchronous reset between edges.
    s4 = cyc + 1;
    expectRun("ch2_p2d1", 2, 2, 1, s4, s4, s4 + 3);
    expectRun("ch1_rerun", 1, 4, 3, s4, s4, s4 + 3);
    applyStimulus(1'b0, 2'd0, '0, '0, 2'd0, '0, 4'b1110, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) idleInputs();
    end
    checkVec("all_busy", 16'(busy), 16'h000F);
    applyStimulus(1'b1, 2'd0, 8'd1, 8'd1, 2'd0, 8'd1, '0, '0);
    tick();
    checkBit("pre_rst_err", cfg_err, 1'b1);
    idleInputs();
    #3;
    rst_n = 1'b0;
    #1;
    checkVec("async_pulse", 16'(pulse), 16'h0);
    checkVec("async_busy", 16'(busy), 16'h0);
    checkVec("async_done", 16'(done), 16'h0);
    checkBit("async_cfg_err", cfg_err, 1'b0);
    #2;
    rst_n = 1'b1;

    // After release every channel runs the default P=3/D=2 pattern again.
    s5 = cyc + 1;
    for (int ch = 0; ch < NUM_CH; ch++) expectRun("post_rst_dflt", ch, 3, 2, s5, s5, s5 + 5);
    applyStimulus(1'b0, 2'd0, '0, '0, 2'd0, '0, 4'b1111, '0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) idleInputs();
    end

    checkInt("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
